inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Sits between the UART receiver and instruction memory inside the debug path, upstream of the pipelined processor.
- Assembles received bytes into 32-bit instruction words and writes them sequentially into instruction memory.
- Loading stops when the HALT instruction has been written.
- Reports completion or error to the debug unit's command FSM.

Parameters:
- NB_DATA, 32, instruction word width
- N_BITS, 8, UART byte width
- NB_ADDR, 10, instruction memory byte-address width (equals ADDRWIDTH)
- HALT_WORD, 32'hFC000000, instruction that terminates loading
- TIMEOUT_CYCLES, 5000000, maximum idle cycles between bytes of one word
- NB_TIMEOUT, 23, width of the timeout counter

Ports:
- clock_i  in  1  system clock (clk_wiz output)
- reset_i  in  1  asynchronous reset, active-high
- start_i  in  1  one-cycle pulse from the debug FSM that begins a load
- rx_byte_i  in  N_BITS  received UART byte
- rx_done_i  in  1  one-cycle strobe; rx_byte_i is valid this cycle
- inst_load_o  out  NB_DATA  word to write to instruction memory
- address_o  out  NB_ADDR  byte address of the write
- en_write_o  out  1  instruction memory write enable, one cycle per word
- busy_o  out  1  high in RECV and WRITE states
- load_done_o  out  1  level; HALT word has been written
- error_o  out  1  level; overflow or timeout occurred
- word_count_o  out  NB_ADDR-1  number of words written

Behaviour:
- Reset (async, active-high): state IDLE. All outputs are 0, including the byte index, shift register and timeout counter.
- IDLE:
  - start_i -> RECV. Clears address, word_count, load_done_o and error_o.
  - rx_done_i is ignored in IDLE.
- RECV:
  - On each rx_done_i the byte is shifted in MSB-first: word <= {word[23:0], rx_byte_i}. The byte index increments and the timeout counter clears.
  - When the 4th byte arrives -> WRITE on the next edge. The byte index wraps to 0.
  - The timeout counter increments on every cycle without rx_done_i, including while the byte index is 0.
  - When the counter reaches TIMEOUT_CYCLES-1 -> ERROR.
  - start_i is ignored in RECV.
- WRITE (exactly one cycle):
  - en_write_o = 1, inst_load_o = assembled word, address_o = current address.
  - Next edge: address += 4, word_count += 1.
  - If word == HALT_WORD -> DONE.
  - Else if address was the last word (2^NB_ADDR - 4) -> ERROR (overflow; address is not wrapped).
  - Else -> RECV.
  - An rx_done_i arriving during WRITE is captured as byte 0 of the next word; no byte may be lost.
- Output timing: en_write_o is registered. Latency from the 4th byte's rx_done_i to en_write_o high is 1 cycle.
- DONE: load_done_o = 1 (held). start_i -> RECV, restarting the load at address 0.
- ERROR: error_o = 1 (held). start_i -> RECV (restart). Partially written memory is not cleaned up.
- Simultaneous start_i and rx_done_i in IDLE/DONE/ERROR: the start takes effect and the byte is discarded.
- Reset mid-load aborts immediately. en_write_o drops asynchronously.
- busy_o = (state == RECV) || (state == WRITE).

Decomposition:
- parameters.vh gains:
  - HALT_WORD define
  - state encodings (LD_IDLE, LD_RECV, LD_WRITE, LD_DONE, LD_ERROR), one-hot, 5 bits
  - LD_TIMEOUT default
- One natural sub-module: byte_assembler.
  - Contains the shift register and the 2-bit byte index.
  - Outputs word_o and word_valid_o.
  - Inputs clear_i and the byte strobe.
- The FSM, address counter and timeout counter stay in inst_loader.

Test Plan:
- Reset then start_i; send bytes 20 01 00 05, 8C 22 00 04, FC 00 00 00.
  - Required: three en_write_o pulses, each 1 cycle after the 4th byte.
  - Writes: addr 0 = 0x20010005, addr 4 = 0x8C220004, addr 8 = 0xFC000000.
  - Then load_done_o = 1, word_count_o = 3, busy_o = 0.
- Send bytes 20 01 with TIMEOUT_CYCLES = 100, then idle for 100 cycles.
  - Required: error_o = 1, no en_write_o pulse.
  - Then start_i plus a full HALT word -> write at address 0, load_done_o = 1.
- NB_ADDR = 4 (4 words); send 4 non-HALT words.
  - Required: 4 writes at 0, 4, 8, 12, then error_o = 1. address_o is not wrapped to 0.
- Drive rx_done_i in the same cycle as en_write_o for word N.
  - Required: that byte becomes the MSB of word N+1; the next write carries the correct value.
- Assert reset_i after 2 of 4 bytes.
  - Required: en_write_o = 0, state IDLE, outputs cleared.
  - A new start_i + FC 00 00 00 -> single write at address 0.
- Send bytes in IDLE without start_i.
  - Required: no en_write_o and no state change.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared constants and FSM state encoding for the instruction loader
package inst_loader_pkg;
  localparam int NB_DATA = 32;
  localparam int N_BITS = 8;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
  localparam int LD_TIMEOUT = 5000000;
  localparam int LD_NB_TIMEOUT = 23;
  typedef enum logic [4:0] {
    LD_IDLE  = 5'b00001,
    LD_RECV  = 5'b00010,
    LD_WRITE = 5'b00100,
    LD_DONE  = 5'b01000,
    LD_ERROR = 5'b10000
  } ld_state_e;
endpackage

// File: rtl/inst_loader_if.sv
// inst_loader_if: debug-side command/byte inputs and instruction-memory write outputs
interface inst_loader_if #(
  parameter int NB_DATA = 32,
  parameter int N_BITS = 8,
  parameter int NB_ADDR = 10
);
  logic start_i;
  logic [N_BITS-1:0] rx_byte_i;
  logic rx_done_i;
  logic [NB_DATA-1:0] inst_load_o;
  logic [NB_ADDR-1:0] address_o;
  logic en_write_o;
  logic busy_o;
  logic load_done_o;
  logic error_o;
  logic [NB_ADDR-2:0] word_count_o;
  modport master(
    output start_i, rx_byte_i, rx_done_i,
    input inst_load_o, address_o, en_write_o, busy_o, load_done_o, error_o, word_count_o
  );
  modport slave(
    input start_i, rx_byte_i, rx_done_i,
    output inst_load_o, address_o, en_write_o, busy_o, load_done_o, error_o, word_count_o
  );
endinterface

// File: rtl/inst_loader_byte_assembler.sv
// inst_loader_byte_assembler: shifts UART bytes MSB-first into a word and flags the last byte
module inst_loader_byte_assembler #(
  parameter int NB_DATA = 32,
  parameter int N_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic strobe_i,
  input  logic [N_BITS-1:0] byte_i,
  output logic [NB_DATA-1:0] word_o,
  output logic word_valid_o
);
  localparam int NB_IDX = $clog2(NB_DATA / N_BITS);
  logic [NB_IDX-1:0] idx;
  assign word_valid_o = strobe_i && (&idx);
  // shift register and byte index; index wraps to 0 after the final byte of a word
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear_i) begin
      word_o <= '0;
      idx <= '0;
    end else if (strobe_i) begin
      word_o <= {word_o[NB_DATA-N_BITS-1:0], byte_i};
      idx <= idx + 1'b1;
    end
  end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: assembles UART bytes into instruction words and writes them until HALT
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int NB_ADDR = 10,
  parameter int TIMEOUT_CYCLES = LD_TIMEOUT,
  parameter int NB_TIMEOUT = LD_NB_TIMEOUT
) (
  input  logic clock_i,
  input  logic reset_i,
  inst_loader_if.slave bus
);
  ld_state_e state;
  logic [NB_DATA-1:0] word;
  logic [NB_ADDR-1:0] address;
  logic [NB_ADDR-2:0] word_count;
  logic [NB_TIMEOUT-1:0] tcnt;
  logic word_valid, accept, start_ok, strobe, last, en_write, load_done, error;
  assign accept = state == LD_RECV || state == LD_WRITE;
  assign start_ok = bus.start_i && !accept;
  assign strobe = bus.rx_done_i && accept;
  assign last = &address[NB_ADDR-1:2];
  assign bus.inst_load_o = word;
  assign bus.address_o = address;
  assign bus.en_write_o = en_write;
  assign bus.busy_o = accept;
  assign bus.load_done_o = load_done;
  assign bus.error_o = error;
  assign bus.word_count_o = word_count;
  inst_loader_byte_assembler #(.NB_DATA(NB_DATA), .N_BITS(N_BITS)) u_asm (
    .clk(clock_i),
    .rst(reset_i),
    .clear_i(start_ok),
    .strobe_i(strobe),
    .byte_i(bus.rx_byte_i),
    .word_o(word),
    .word_valid_o(word_valid)
  );
  // load FSM with address, word and idle-timeout counters; a byte arriving in WRITE is kept by the assembler
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= LD_IDLE;
      address <= '0;
      word_count <= '0;
      tcnt <= '0;
      en_write <= 1'b0;
      load_done <= 1'b0;
      error <= 1'b0;
    end else begin
      en_write <= 1'b0;
      case (state)
        LD_IDLE, LD_DONE, LD_ERROR: if (bus.start_i) begin
          state <= LD_RECV;
          address <= '0;
          word_count <= '0;
          tcnt <= '0;
          load_done <= 1'b0;
          error <= 1'b0;
        end
        LD_RECV: begin
          if (word_valid) begin
            state <= LD_WRITE;
            en_write <= 1'b1;
            tcnt <= '0;
          end else if (bus.rx_done_i) tcnt <= '0;
          else if (tcnt == NB_TIMEOUT'(TIMEOUT_CYCLES - 1)) begin
            state <= LD_ERROR;
            error <= 1'b1;
          end else tcnt <= tcnt + 1'b1;
        end
        LD_WRITE: begin
          word_count <= word_count + 1'b1;
          tcnt <= bus.rx_done_i ? '0 : tcnt + 1'b1;
          address <= last ? address : address + NB_ADDR'(4);
          if (word == HALT_WORD) begin
            state <= LD_DONE;
            load_done <= 1'b1;
          end else if (last) begin
            state <= LD_ERROR;
            error <= 1'b1;
          end else state <= LD_RECV;
        end
        default: state <= LD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: randomized self-checking bench for inst_loader against a word-level model
module tb_inst_loader;
  import inst_loader_pkg::*;
  localparam int NA = 4;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [NA-1:0] wq_a[$];
  logic [31:0] wq_d[$];

  always #5 clk = ~clk;

  inst_loader_if #(.NB_DATA(32), .N_BITS(8), .NB_ADDR(NA)) bus();

  inst_loader #(.NB_ADDR(NA), .TIMEOUT_CYCLES(TO), .NB_TIMEOUT(7)) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus(bus)
  );

  // record every memory write seen mid-cycle
  always @(negedge clk) if (bus.en_write_o === 1'b1) begin
    wq_a.push_back(bus.address_o);
    wq_d.push_back(bus.inst_load_o);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    tick(gap);
    bus.rx_byte_i = b;
    bus.rx_done_i = 1'b1;
    @(negedge clk);
    bus.rx_done_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax, output logic ew);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8+:8], int'($urandom_range(gmax)));
    ew = bus.en_write_o;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    return (w == HALT_WORD) ? ~w : w;
  endfunction

  task automatic test_reset;
    tick(3);
    checks++; if (bus.en_write_o !== 1'b0) begin errors++; $display("FAIL reset_en_write: got %b expected 0", bus.en_write_o); end
    checks++; if ({bus.busy_o, bus.load_done_o, bus.error_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.busy_o, bus.load_done_o, bus.error_o}); end
    checks++; if ({bus.address_o, bus.word_count_o, bus.inst_load_o} !== '0) begin errors++; $display("FAIL reset_data: addr %h count %h word %h expected all 0", bus.address_o, bus.word_count_o, bus.inst_load_o); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic;
    logic [31:0] w[3] = '{32'h2001_0005, 32'h8C22_0004, 32'hFC00_0000};
    logic ew;
    wq_a.delete(); wq_d.delete();
    pulse_start();
    foreach (w[i]) begin
      send_word(w[i], 2, ew);
      checks++; if (ew !== 1'b1) begin errors++; $display("FAIL basic_latency word %0d: en_write %b expected 1", i, ew); end
    end
    tick(2);
    checks++; if (wq_d.size() != 3) begin errors++; $display("FAIL basic_count: got %0d writes expected 3", wq_d.size()); end
    foreach (w[i]) begin
      checks++;
      if (i >= wq_d.size() || wq_a[i] !== NA'(4 * i) || wq_d[i] !== w[i]) begin
        errors++; $display("FAIL basic_write %0d: got %h@%h expected %h@%h", i, (i < wq_d.size()) ? wq_d[i] : 32'hx, (i < wq_a.size()) ? wq_a[i] : 'x, w[i], NA'(4 * i));
      end
    end
    checks++; if ({bus.load_done_o, bus.error_o, bus.busy_o} !== 3'b100) begin errors++; $display("FAIL basic_flags: done/err/busy %b expected 100", {bus.load_done_o, bus.error_o, bus.busy_o}); end
    checks++; if (bus.word_count_o !== 3'd3) begin errors++; $display("FAIL basic_word_count: got %0d expected 3", bus.word_count_o); end
  endtask

  task automatic test_timeout;
    logic ew;
    wq_a.delete(); wq_d.delete();
    pulse_start();
    send_byte(8'h20, 1);
    send_byte(8'h01, 1);
    tick(90);
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL timeout_early: error %b expected 0", bus.error_o); end
    tick(15);
    checks++; if ({bus.error_o, bus.busy_o, bus.load_done_o} !== 3'b100) begin errors++; $display("FAIL timeout_flags: err/busy/done %b expected 100", {bus.error_o, bus.busy_o, bus.load_done_o}); end
    checks++; if (wq_d.size() != 0) begin errors++; $display("FAIL timeout_no_write: got %0d writes expected 0", wq_d.size()); end
    pulse_start();
    checks++; if ({bus.error_o, bus.busy_o} !== 2'b01) begin errors++; $display("FAIL timeout_restart: err/busy %b expected 01", {bus.error_o, bus.busy_o}); end
    send_word(HALT_WORD, 2, ew);
    tick(2);
    checks++; if (ew !== 1'b1) begin errors++; $display("FAIL timeout_halt_latency: en_write %b expected 1", ew); end
    checks++;
    if (wq_d.size() != 1 || wq_a[0] !== '0 || wq_d[0] !== HALT_WORD || bus.load_done_o !== 1'b1) begin
      errors++; $display("FAIL timeout_halt_write: %0d writes, done %b expected 1 write of HALT at 0, done 1", wq_d.size(), bus.load_done_o);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] w[4];
    logic ew;
    foreach (w[i]) w[i] = rand_word();
    wq_a.delete(); wq_d.delete();
    pulse_start();
    foreach (w[i]) send_word(w[i], 3, ew);
    tick(2);
    checks++; if (wq_d.size() != 4) begin errors++; $display("FAIL overflow_count: got %0d writes expected 4", wq_d.size()); end
    foreach (w[i]) begin
      checks++;
      if (i >= wq_d.size() || wq_a[i] !== NA'(4 * i) || wq_d[i] !== w[i]) begin
        errors++; $display("FAIL overflow_write %0d: expected %h@%h", i, w[i], NA'(4 * i));
      end
    end
    checks++; if ({bus.error_o, bus.load_done_o, bus.busy_o} !== 3'b100) begin errors++; $display("FAIL overflow_flags: err/done/busy %b expected 100", {bus.error_o, bus.load_done_o, bus.busy_o}); end
    checks++; if (bus.address_o !== NA'(12)) begin errors++; $display("FAIL overflow_address: got %0d expected 12", bus.address_o); end
    checks++; if (bus.word_count_o !== 3'd4) begin errors++; $display("FAIL overflow_word_count: got %0d expected 4", bus.word_count_o); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a = rand_word();
    logic [31:0] b = rand_word();
    logic [95:0] s = {a, b, HALT_WORD};
    logic [31:0] exp_d[3] = '{a, b, HALT_WORD};
    wq_a.delete(); wq_d.delete();
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      send_byte(s[95-8*k -: 8], 0);
      if (k == 3 || k == 7) begin
        checks++; if (bus.en_write_o !== 1'b1) begin errors++; $display("FAIL b2b_latency byte %0d: en_write %b expected 1", k, bus.en_write_o); end
      end
    end
    tick(2);
    checks++; if (wq_d.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d writes expected 3", wq_d.size()); end
    foreach (exp_d[i]) begin
      checks++;
      if (i >= wq_d.size() || wq_a[i] !== NA'(4 * i) || wq_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL b2b_write %0d: got %h expected %h@%h", i, (i < wq_d.size()) ? wq_d[i] : 32'hx, exp_d[i], NA'(4 * i));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic ew;
    pulse_start();
    send_word(rand_word(), 1, ew);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.en_write_o, bus.busy_o, bus.load_done_o, bus.error_o} !== 4'b0000) begin errors++; $display("FAIL midreset_flags: got %b expected 0000", {bus.en_write_o, bus.busy_o, bus.load_done_o, bus.error_o}); end
    checks++; if ({bus.address_o, bus.word_count_o} !== '0) begin errors++; $display("FAIL midreset_counters: addr %0d count %0d expected 0", bus.address_o, bus.word_count_o); end
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    wq_a.delete(); wq_d.delete();
    pulse_start();
    send_word(HALT_WORD, 1, ew);
    tick(2);
    checks++;
    if (wq_d.size() != 1 || wq_a[0] !== '0 || wq_d[0] !== HALT_WORD || bus.load_done_o !== 1'b1) begin
      errors++; $display("FAIL midreset_reload: %0d writes, done %b expected 1 write of HALT at 0, done 1", wq_d.size(), bus.load_done_o);
    end
  endtask

  task automatic test_idle_bytes;
    logic ew;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wq_a.delete(); wq_d.delete();
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0);
    tick(2);
    checks++; if (wq_d.size() != 0 || {bus.busy_o, bus.load_done_o, bus.error_o} !== 3'b000) begin errors++; $display("FAIL idle_ignore: %0d writes, flags %b expected 0 writes, 000", wq_d.size(), {bus.busy_o, bus.load_done_o, bus.error_o}); end
    for (int r = 0; r < 2; r++) begin
      wq_a.delete(); wq_d.delete();
      bus.start_i = 1'b1; bus.rx_done_i = 1'b1; bus.rx_byte_i = 8'hAA;
      @(negedge clk);
      bus.start_i = 1'b0; bus.rx_done_i = 1'b0;
      send_word(HALT_WORD, 1, ew);
      tick(2);
      checks++;
      if (wq_d.size() != 1 || wq_d[0] !== HALT_WORD || bus.load_done_o !== 1'b1) begin
        errors++; $display("FAIL start_with_byte %0d: %0d writes first %h expected 1 write of %h", r, wq_d.size(), (wq_d.size() > 0) ? wq_d[0] : 32'hx, HALT_WORD);
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      logic [31:0] w[4];
      int p = int'($urandom_range(4));
      int n = (p < 4) ? p + 1 : 4;
      logic ew;
      foreach (w[i]) w[i] = rand_word();
      if (p < 4) w[p] = HALT_WORD;
      wq_a.delete(); wq_d.delete();
      pulse_start();
      for (int i = 0; i < n; i++) begin
        send_word(w[i], 5, ew);
        checks++; if (ew !== 1'b1) begin errors++; $display("FAIL rand_latency it %0d word %0d: en_write %b expected 1", it, i, ew); end
      end
      tick(2);
      checks++; if (wq_d.size() != n) begin errors++; $display("FAIL rand_count it %0d: got %0d writes expected %0d", it, wq_d.size(), n); end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (i >= wq_d.size() || wq_a[i] !== NA'(4 * i) || wq_d[i] !== w[i]) begin
          errors++; $display("FAIL rand_write it %0d word %0d: expected %h@%h", it, i, w[i], NA'(4 * i));
        end
      end
      checks++;
      if ({bus.load_done_o, bus.error_o} !== {p < 4, p == 4} || bus.word_count_o !== 3'(n)) begin
        errors++; $display("FAIL rand_status it %0d: done/err %b count %0d expected %b count %0d", it, {bus.load_done_o, bus.error_o}, bus.word_count_o, {p < 4, p == 4}, n);
      end
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.rx_done_i = 1'b0;
    bus.rx_byte_i = '0;
    test_reset();
    test_basic();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_idle_bytes();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
